code_checker: RTL and testbench

- Scoring end of the CodeBreak game. The randomizer produces a 16-bit secret of four 4-bit digits; this block consumes it.
- Latches the secret on a new-game load, then accepts player guesses over a valid/ready handshake.
- Scores each guess as exact matches (right digit, right position) and partial matches (right digit, wrong position).
- Tracks attempts and declares win or lose; results feed the display/UI logic.

---
 rtl/code_checker.sv | 194 +++++++++++++++++++
 tb/tb_code_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/code_checker.sv
// CodeBreak scorer: latches a secret on load, then scores handshaked guesses
// into exact/partial counts, tracks tries and holds win/lose until the next load.
module code_checker #(
   parameter  int DIGITS    = 4,
   parameter  int DIGIT_W   = 4,
   parameter  int DIGIT_MAX = 9,
   parameter  int MAX_TRIES = 10,
   localparam int CODE_W    = DIGITS*DIGIT_W,
   localparam int CNT_W     = $clog2(DIGITS+1),
   localparam int TRY_W     = $clog2(MAX_TRIES+1),
   localparam int K_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [CODE_W-1:0] secret,
   input  logic              guess_valid,
   input  logic [CODE_W-1:0] guess,
   output logic              guess_ready,
   output logic              result_valid,
   output logic [CNT_W-1:0]  exact,
   output logic [CNT_W-1:0]  partial,
   output logic              err,
   output logic [TRY_W-1:0]  tries,
   output logic              win,
   output logic              lose
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_READY   = 3'd1;
   localparam logic [2:0] S_EXACT   = 3'd2;
   localparam logic [2:0] S_PARTIAL = 3'd3;
   localparam logic [2:0] S_RESULT  = 3'd4;
   localparam logic [2:0] S_WON     = 3'd5;
   localparam logic [2:0] S_LOST    = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [CODE_W-1:0] secret_q, secret_d, guess_q, guess_d;
   logic [DIGITS-1:0] used_s_q, used_s_d, used_g_q, used_g_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [CNT_W-1:0]  ecnt_q, ecnt_d, pcnt_q, pcnt_d;
   logic              bad_q, bad_d;
   logic              ready_q, ready_d, rv_q, rv_d;
   logic [CNT_W-1:0]  exact_q, exact_d, partial_q, partial_d;
   logic              err_q, err_d, win_q, win_d, lose_q, lose_d;
   logic [TRY_W-1:0]  tries_q, tries_d;

   logic [DIGIT_W-1:0] sd [DIGITS];
   logic [DIGIT_W-1:0] gd [DIGITS];
   logic               found;

   always_comb begin
      state_d   = state_q;
      secret_d  = secret_q;
      guess_d   = guess_q;
      used_s_d  = used_s_q;
      used_g_d  = used_g_q;
      k_d       = k_q;
      ecnt_d    = ecnt_q;
      pcnt_d    = pcnt_q;
      bad_d     = bad_q;
      rv_d      = 1'b0;
      exact_d   = exact_q;
      partial_d = partial_q;
      err_d     = err_q;
      win_d     = win_q;
      lose_d    = lose_q;
      tries_d   = tries_q;
      found     = 1'b0;
      // digit 0 is the most significant nibble
      for (int i = 0; i < DIGITS; i++) begin
         sd[i] = secret_q[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
         gd[i] = guess_q[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
      end
      if (load) begin
         secret_d  = secret;
         tries_d   = '0;
         win_d     = 1'b0;
         lose_d    = 1'b0;
         err_d     = 1'b0;
         exact_d   = '0;
         partial_d = '0;
         state_d   = S_READY;
      end else begin
         case (state_q)
            S_READY: if (guess_valid && ready_q) begin
               guess_d = guess;
               state_d = S_EXACT;
            end
            S_EXACT: begin
               used_s_d = '0;
               used_g_d = '0;
               ecnt_d   = '0;
               pcnt_d   = '0;
               bad_d    = 1'b0;
               k_d      = '0;
               for (int i = 0; i < DIGITS; i++) begin
                  if (sd[i] == gd[i]) begin
                     used_s_d[i] = 1'b1;
                     used_g_d[i] = 1'b1;
                     ecnt_d      = ecnt_d + CNT_W'(1);
                  end
                  if (gd[i] > DIGIT_W'(DIGIT_MAX)) bad_d = 1'b1;
               end
               state_d = S_PARTIAL;
            end
            S_PARTIAL: begin
               // one guess digit per cycle claims the lowest free secret slot
               if (!used_g_q[k_q]) begin
                  for (int i = 0; i < DIGITS; i++) begin
                     if (!found && !used_s_q[i] && sd[i] == gd[k_q]) begin
                        found       = 1'b1;
                        used_s_d[i] = 1'b1;
                     end
                  end
                  if (found) pcnt_d = pcnt_q + CNT_W'(1);
               end
               if (k_q == K_W'(DIGITS-1)) state_d = S_RESULT;
               else                       k_d     = k_q + K_W'(1);
            end
            S_RESULT: begin
               rv_d      = 1'b1;
               exact_d   = ecnt_q;
               partial_d = pcnt_q;
               err_d     = bad_q;
               if (bad_q) begin
                  state_d = S_READY;
               end else begin
                  tries_d = tries_q + TRY_W'(1);
                  if (ecnt_q == CNT_W'(DIGITS)) begin
                     state_d = S_WON;
                     win_d   = 1'b1;
                  end else if (tries_q + TRY_W'(1) == TRY_W'(MAX_TRIES)) begin
                     state_d = S_LOST;
                     lose_d  = 1'b1;
                  end else begin
                     state_d = S_READY;
                  end
               end
            end
            default: ;
         endcase
      end
      ready_d = (state_d == S_READY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         secret_q  <= '0;
         guess_q   <= '0;
         used_s_q  <= '0;
         used_g_q  <= '0;
         k_q       <= '0;
         ecnt_q    <= '0;
         pcnt_q    <= '0;
         bad_q     <= 1'b0;
         ready_q   <= 1'b0;
         rv_q      <= 1'b0;
         exact_q   <= '0;
         partial_q <= '0;
         err_q     <= 1'b0;
         win_q     <= 1'b0;
         lose_q    <= 1'b0;
         tries_q   <= '0;
      end else begin
         state_q   <= state_d;
         secret_q  <= secret_d;
         guess_q   <= guess_d;
         used_s_q  <= used_s_d;
         used_g_q  <= used_g_d;
         k_q       <= k_d;
         ecnt_q    <= ecnt_d;
         pcnt_q    <= pcnt_d;
         bad_q     <= bad_d;
         ready_q   <= ready_d;
         rv_q      <= rv_d;
         exact_q   <= exact_d;
         partial_q <= partial_d;
         err_q     <= err_d;
         win_q     <= win_d;
         lose_q    <= lose_d;
         tries_q   <= tries_d;
      end
   end

   assign guess_ready  = ready_q;
   assign result_valid = rv_q;
   assign exact        = exact_q;
   assign partial      = partial_q;
   assign err          = err_q;
   assign tries        = tries_q;
   assign win          = win_q;
   assign lose         = lose_q;
endmodule

// File: tb/tb_code_checker.sv
// Bench for code_checker: directed scenarios plus random games, scored by a
// multiset reference model (exact + sum of per-digit min counts).
module tb_code_checker;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] secret = '0;
   logic        guess_valid = 1'b0;
   logic [15:0] guess = '0;
   logic        guess_ready, result_valid, err, win, lose;
   logic [2:0]  exact, partial;
   logic [3:0]  tries;

   int checks = 0;
   int fails  = 0;

   logic [15:0] m_secret;
   int          m_tries;
   bit          m_win, m_lose;

   code_checker dut (
      .clk(clk), .rst(rst), .load(load), .secret(secret),
      .guess_valid(guess_valid), .guess(guess), .guess_ready(guess_ready),
      .result_valid(result_valid), .exact(exact), .partial(partial),
      .err(err), .tries(tries), .win(win), .lose(lose)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   function automatic void score(input logic [15:0] s, input logic [15:0] g,
                                 output int e, output int p, output bit bad);
      int cs [16];
      int cg [16];
      int tot;
      logic [3:0] a, b;
      e = 0; tot = 0; bad = 0;
      for (int v = 0; v < 16; v++) begin cs[v] = 0; cg[v] = 0; end
      for (int i = 0; i < 4; i++) begin
         a = s[(3-i)*4 +: 4];
         b = g[(3-i)*4 +: 4];
         if (a == b) e++;
         if (b > 4'd9) bad = 1;
         cs[a]++;
         cg[b]++;
      end
      for (int v = 0; v < 16; v++) tot += (cs[v] < cg[v]) ? cs[v] : cg[v];
      p = tot - e;
   endfunction

   task automatic do_load(input logic [15:0] s);
      @(negedge clk);
      load = 1'b1; secret = s;
      @(negedge clk);
      load = 1'b0;
      m_secret = s; m_tries = 0; m_win = 0; m_lose = 0;
      chk("load_ready", guess_ready, 1);
      chk("load_tries", tries, 0);
      chk("load_wl", {win, lose, err}, 0);
   endtask

   task automatic do_guess(input logic [15:0] g);
      int n, lat, e, p;
      bit bad;
      n = 0;
      while (!guess_ready && n < 50) begin @(negedge clk); n++; end
      if (!guess_ready) begin chk("ready_timeout", guess_ready, 1); return; end
      guess = g; guess_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      guess_valid = 1'b0;
      lat = 0;
      while (!result_valid && lat < 20) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      chk("latency", lat, 6);
      score(m_secret, g, e, p, bad);
      if (!bad) begin
         m_tries++;
         if (e == 4)            m_win = 1;
         else if (m_tries == 10) m_lose = 1;
      end
      chk("exact", exact, e);
      chk("partial", partial, p);
      chk("err", err, bad);
      chk("tries", tries, m_tries);
      chk("win", win, m_win);
      chk("lose", lose, m_lose);
      chk("ready_after", guess_ready, !(m_win || m_lose));
      @(negedge clk);
      chk("rv_pulse", result_valid, 0);
   endtask

   task automatic watch_no_rv(input string tag, input int cycles);
      bit seen = 0;
      repeat (cycles) begin @(negedge clk); if (result_valid) seen = 1; end
      chk(tag, seen, 0);
   endtask

   function automatic logic [15:0] rand_code(input bit allow_bad);
      logic [15:0] c;
      for (int i = 0; i < 4; i++)
         c[i*4 +: 4] = (allow_bad && $urandom_range(0, 7) == 0) ?
                       4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      return c;
   endfunction

   initial begin
      logic [15:0] s, g;
      int r;
      // reset state
      #12;
      chk("rst_outs", {guess_ready, result_valid, exact, partial, err, tries, win, lose}, 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", guess_ready, 0);

      // win on exact guess
      do_load(16'h1234);
      do_guess(16'h1234);

      // repeated digits
      do_load(16'h1123);
      do_guess(16'h3111);
      do_load(16'h1234);
      do_guess(16'h4321);

      // invalid digit, then a clean miss
      do_load(16'h1234);
      do_guess(16'h12A4);
      do_guess(16'h5678);

      // lose after MAX_TRIES misses, further guesses ignored
      do_load(16'h1234);
      repeat (10) do_guess(16'h5678);
      @(negedge clk); guess = 16'h1234; guess_valid = 1'b1;
      watch_no_rv("lost_ignore", 12);
      guess_valid = 1'b0;
      chk("lost_tries", tries, 10);
      chk("lost_ready", guess_ready, 0);

      // abort by load two cycles after accept
      do_load(16'h1234);
      @(negedge clk); guess = 16'h5678; guess_valid = 1'b1;
      @(posedge clk);
      @(negedge clk); guess_valid = 1'b0;
      @(negedge clk); load = 1'b1; secret = 16'h9999;
      @(negedge clk); load = 1'b0;
      m_secret = 16'h9999; m_tries = 0; m_win = 0; m_lose = 0;
      watch_no_rv("abort_rv", 10);
      chk("abort_tries", tries, 0);
      chk("abort_ready", guess_ready, 1);
      do_guess(16'h9990);

      // asynchronous reset mid-PARTIAL
      do_load(16'h1234);
      do_guess(16'h5674);
      @(negedge clk); guess = 16'h1111; guess_valid = 1'b1;
      @(posedge clk);
      @(negedge clk); guess_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("async_rst", {guess_ready, result_valid, exact, partial, err, tries, win, lose}, 0);
      @(negedge clk); rst = 1'b0;
      watch_no_rv("rst_no_rv", 8);
      chk("rst_idle", guess_ready, 0);

      // load and guess_valid in the same cycle
      do_load(16'h1234);
      @(negedge clk); load = 1'b1; secret = 16'h1234; guess = 16'h1234; guess_valid = 1'b1;
      @(negedge clk); load = 1'b0; guess_valid = 1'b0;
      watch_no_rv("ld_gv_rv", 10);
      chk("ld_gv_tries", tries, 0);
      chk("ld_gv_ready", guess_ready, 1);

      // random games
      for (int gm = 0; gm < 8; gm++) begin
         s = rand_code(gm[0]);
         do_load(s);
         for (int t = 0; t < 13 && !(m_win || m_lose); t++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      g = s;
            else if (r == 1) g = {s[7:0], s[15:8]};
            else if (r == 2) g = {s[3:0], s[15:4]};
            else             g = rand_code(r == 3);
            do_guess(g);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end
endmodule
